// File: rtl/div_sched_if.sv
// Bundle of the EX-side request/response and the divider start/annul/ready
// signals used by div_sched.
//   slave  : div_sched side (consumes EX request and divider result)
//   master : environment side (EX stage + divider)
// EX side : req_i, op_i, opdata1_i, opdata2_i, flush_i -> stallreq_o, result_o, result_valid_o
// Div side: div_start_o, div_annul_o, signed_div_o, div_opdata1_o, div_opdata2_o <- div_result_i, div_ready_i
interface div_sched_if #(parameter int WIDTH = 32);
  logic               req_i;
  logic [1:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               flush_i;
  logic               stallreq_o;
  logic [WIDTH-1:0]   result_o;
  logic               result_valid_o;
  logic               div_start_o;
  logic               div_annul_o;
  logic               signed_div_o;
  logic [WIDTH-1:0]   div_opdata1_o;
  logic [WIDTH-1:0]   div_opdata2_o;
  logic [2*WIDTH-1:0] div_result_i;
  logic               div_ready_i;

  modport slave (
    input  req_i, op_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
    output stallreq_o, result_o, result_valid_o, div_start_o, div_annul_o,
           signed_div_o, div_opdata1_o, div_opdata2_o
  );

  modport master (
    output req_i, op_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
    input  stallreq_o, result_o, result_valid_o, div_start_o, div_annul_o,
           signed_div_o, div_opdata1_o, div_opdata2_o
  );
endinterface

// File: rtl/div_sched.sv
// div_sched: sequences RV32M DIV/DIVU/REM/REMU between EX and a shared
// multi-cycle divider. Divide-by-zero and signed overflow are answered in the
// same cycle; a one-entry cache returns the other half (quotient/remainder)
// of the last divide without re-running the divider.
// Ports: clk, rst (sync, active high); bus (div_sched_if.slave) carries the
// EX request/response and the divider start/annul/ready handshake.
module div_sched #(
  parameter int WIDTH    = 32,
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  div_sched_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] lat_a, lat_b, res_q;
  logic             lat_sgn, lat_sel;
  logic [WIDTH-1:0] tag_a, tag_b, c_quo, c_rem;
  logic             tag_sgn, c_vld;

  logic             sgn, sel, div0, ovf, special, hit, idle_req, miss;
  logic [WIDTH-1:0] spec_res, hit_res, d_quo, d_rem;

  assign sgn      = ~bus.op_i[0];
  assign sel      = bus.op_i[1];
  assign div0     = (bus.opdata2_i == '0);
  assign ovf      = sgn && (bus.opdata1_i == MSB_ONLY) && (bus.opdata2_i == '1);
  assign special  = div0 | ovf;
  // divide-by-zero wins over overflow
  assign spec_res = div0 ? (sel ? bus.opdata1_i : '1)
                         : (sel ? '0 : bus.opdata1_i);
  assign hit      = (CACHE_EN != 0) && c_vld && (tag_a == bus.opdata1_i) &&
                    (tag_b == bus.opdata2_i) && (tag_sgn == sgn);
  assign hit_res  = sel ? c_rem : c_quo;
  assign idle_req = (state == IDLE) && bus.req_i && !bus.flush_i;
  assign miss     = idle_req && !special && !hit;
  assign d_quo    = bus.div_result_i[WIDTH-1:0];
  assign d_rem    = bus.div_result_i[2*WIDTH-1:WIDTH];

  always_comb begin
    bus.stallreq_o     = 1'b0;
    bus.result_o       = '0;
    bus.result_valid_o = 1'b0;
    bus.div_start_o    = 1'b0;
    bus.div_annul_o    = 1'b0;
    bus.signed_div_o   = 1'b0;
    bus.div_opdata1_o  = '0;
    bus.div_opdata2_o  = '0;
    case (state)
      IDLE: begin
        if (idle_req) begin
          if (special) begin
            bus.result_valid_o = 1'b1;
            bus.result_o       = spec_res;
          end else if (hit) begin
            bus.result_valid_o = 1'b1;
            bus.result_o       = hit_res;
          end else begin
            bus.stallreq_o     = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          bus.div_annul_o   = 1'b1;
        end else begin
          bus.div_start_o   = 1'b1;
          bus.stallreq_o    = 1'b1;
          bus.signed_div_o  = lat_sgn;
          bus.div_opdata1_o = lat_a;
          bus.div_opdata2_o = lat_b;
        end
      end
      DONE: begin
        if (!bus.flush_i) begin
          bus.result_valid_o = 1'b1;
          bus.result_o       = res_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_sgn <= 1'b0;
      lat_sel <= 1'b0;
      res_q   <= '0;
      tag_a   <= '0;
      tag_b   <= '0;
      tag_sgn <= 1'b0;
      c_quo   <= '0;
      c_rem   <= '0;
      c_vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_a   <= bus.opdata1_i;
            lat_b   <= bus.opdata2_i;
            lat_sgn <= sgn;
            lat_sel <= sel;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // flush wins over a same-cycle ready: result is dropped, cache kept
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (bus.div_ready_i) begin
            res_q   <= lat_sel ? d_rem : d_quo;
            tag_a   <= lat_a;
            tag_b   <= lat_b;
            tag_sgn <= lat_sgn;
            c_quo   <= d_quo;
            c_rem   <= d_rem;
            c_vld   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_sched_if #(.WIDTH(W)) bus();

  div_sched #(.WIDTH(W), .CACHE_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference cache contents: last completed divider run
  bit        cv = 0;
  logic [31:0] ca = '0, cb = '0;
  bit        cs = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // divider behaviour: RISC-V truncating division, {rem, quo}
  function automatic logic [63:0] div_model(input logic [31:0] a, b, input bit sgn);
    logic [31:0] q, r;
    if (b == 0) return '0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, b);
    logic [63:0] qr;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    qr = div_model(a, b, !op[0]);
    return op[1] ? qr[63:32] : qr[31:0];
  endfunction

  function automatic bit ref_fast(input logic [1:0] op, input logic [31:0] a, b);
    return is_special(op, a, b) || (cv && ca == a && cb == b && cs == !op[0]);
  endfunction

  function automatic logic [63:0] all_outs();
    return {32'(bus.stallreq_o) ^ 32'(bus.result_valid_o) ^ 32'(bus.div_start_o) ^
            32'(bus.div_annul_o) ^ 32'(bus.signed_div_o) ^ {31'd0, 1'b0},
            bus.result_o | bus.div_opdata1_o | bus.div_opdata2_o} |
           {63'd0, bus.stallreq_o | bus.result_valid_o | bus.div_start_o |
                   bus.div_annul_o | bus.signed_div_o};
  endfunction

  // Entered and left #1 after a posedge. flush_at/rst_at: busy cycle (1-based)
  // at which to flush / reset; 0 = none.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a, b,
                       input int n, input logic [31:0] exp, input bit fast,
                       input int flush_at, input int rst_at);
    int cyc = 0;
    int scnt = 0;
    bit done = 0;
    bus.req_i = 1; bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b; bus.flush_i = 0;
    while (!done && cyc < n + 8) begin
      bus.div_ready_i = 0; bus.div_result_i = '0;
      #1;
      if (bus.div_start_o) scnt++;
      if (flush_at > 0 && scnt == flush_at) begin
        bus.flush_i = 1; bus.div_ready_i = 1;
        bus.div_result_i = div_model(bus.div_opdata1_o, bus.div_opdata2_o, bus.signed_div_o);
        #1;
        chk({name, "_annul"}, 64'(bus.div_annul_o), 64'd1);
        chk({name, "_fl_start"}, 64'(bus.div_start_o), 64'd0);
        chk({name, "_fl_stall"}, 64'(bus.stallreq_o), 64'd0);
        chk({name, "_fl_valid"}, 64'(bus.result_valid_o), 64'd0);
        @(posedge clk); #1;
        bus.flush_i = 0; bus.req_i = 0; bus.div_ready_i = 0;
        #1;
        chk({name, "_annul_once"}, 64'(bus.div_annul_o), 64'd0);
        chk({name, "_fl_idle"}, 64'({bus.div_start_o, bus.stallreq_o, bus.result_valid_o}), 64'd0);
        done = 1;
      end else if (rst_at > 0 && scnt == rst_at) begin
        rst = 1; bus.req_i = 0;
        @(posedge clk); #1;
        #1;
        chk({name, "_rst_outs"}, all_outs(), 64'd0);
        rst = 0;
        cv = 0;
        done = 1;
      end else begin
        if (bus.div_start_o && scnt == n) begin
          bus.div_ready_i = 1;
          bus.div_result_i = div_model(bus.div_opdata1_o, bus.div_opdata2_o, bus.signed_div_o);
          #1;
        end
        if (bus.result_valid_o) begin
          chk({name, "_result"}, 64'(bus.result_o), 64'(exp));
          chk({name, "_latency"}, 64'(cyc), fast ? 64'd0 : 64'(n + 1));
          chk({name, "_starts"}, 64'(scnt), fast ? 64'd0 : 64'(n));
          chk({name, "_vstall"}, 64'(bus.stallreq_o), 64'd0);
          if (!fast) begin cv = 1; ca = a; cb = b; cs = !op[0]; end
          @(posedge clk); #1;
          bus.req_i = 0; bus.div_ready_i = 0;
          done = 1;
        end else begin
          chk({name, "_stall"}, 64'(bus.stallreq_o), 64'd1);
          chk({name, "_res0"}, 64'(bus.result_o), 64'd0);
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no result after %0d cycles, required %0d", name, cyc, n + 1);
      bus.req_i = 0;
    end
  endtask

  // idle cycle with a stray ready: must be ignored
  task automatic idle_chk(input string name);
    bus.req_i = 0; bus.flush_i = 0; bus.div_ready_i = 1; bus.div_result_i = {32'hDEAD, 32'hBEEF};
    #1;
    chk({name, "_idle_outs"}, all_outs(), 64'd0);
    @(posedge clk); #1;
    bus.div_ready_i = 0;
    #1;
    chk({name, "_idle_after"}, 64'({bus.result_valid_o, bus.div_start_o}), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"div_100_7",   2'b00, 32'd100,       32'd7,         4, 32'd14,        0};
    vecs[1] = '{"rem_hit",     2'b10, 32'd100,       32'd7,         4, 32'd2,         1};
    vecs[2] = '{"divu_by0",    2'b01, 32'h1234_5678, 32'd0,         4, 32'hFFFF_FFFF, 1};
    vecs[3] = '{"remu_by0",    2'b11, 32'h1234_5678, 32'd0,         4, 32'h1234_5678, 1};
    vecs[4] = '{"div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'h8000_0000, 1};
    vecs[5] = '{"rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'h0,         1};
    vecs[6] = '{"divu_noovf",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'h0,         0};
    vecs[7] = '{"div_neg",     2'b00, 32'hFFFF_FFF9, 32'd2,         6, 32'hFFFF_FFFD, 0};
    vecs[8] = '{"divu_sgnmiss",2'b01, 32'hFFFF_FFF9, 32'd2,         2, 32'h7FFF_FFFC, 0};
    vecs[9] = '{"remu_hit",    2'b11, 32'hFFFF_FFF9, 32'd2,         2, 32'd1,         1};

    bus.req_i = 0; bus.op_i = 0; bus.opdata1_i = 0; bus.opdata2_i = 0; bus.flush_i = 0;
    bus.div_result_i = '0; bus.div_ready_i = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n,
                            vecs[i].exp, vecs[i].fast, 0, 0);
    idle_chk("after_table");

    // flush in IDLE: nothing latched, divider never started
    bus.req_i = 1; bus.op_i = 2'b00; bus.opdata1_i = 32'd12345; bus.opdata2_i = 32'd17; bus.flush_i = 1;
    #1;
    chk("idle_flush_stall", 64'(bus.stallreq_o), 64'd0);
    chk("idle_flush_valid", 64'(bus.result_valid_o), 64'd0);
    @(posedge clk); #1;
    bus.req_i = 0; bus.flush_i = 0;
    #1;
    chk("idle_flush_nostart", 64'(bus.div_start_o), 64'd0);
    @(posedge clk); #1;

    // flush mid-divide with a same-cycle ready, then re-issue misses
    issue("flush5", 2'b00, 32'd1000, 32'd3, 10, 32'd333, 0, 5, 0);
    issue("reissue", 2'b00, 32'd1000, 32'd3, 10, 32'd333, 0, 0, 0);

    // reset mid-divide invalidates the cache
    issue("pre_rst", 2'b00, 32'd77, 32'd5, 3, 32'd15, 0, 0, 0);
    issue("rst_mid", 2'b00, 32'd9, 32'd4, 8, 32'd2, 0, 0, 3);
    issue("rem_after_rst", 2'b10, 32'd77, 32'd5, 2, 32'd2, 0, 0, 0);
    idle_chk("after_rst");

    // randomized traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          n;
      op = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, 5);
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: begin a = ca; b = cb; if (b == 0) b = 1; end
        4: begin a = $urandom_range(0, 200); b = $urandom_range(1, 9); end
        default: begin a = $urandom; b = $urandom; if (b == 0) b = 3; end
      endcase
      issue("rnd", op, a, b, n, ref_res(op, a, b), ref_fast(op, a, b), 0, 0);
      if ($urandom_range(0, 3) == 0) idle_chk("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
